// File: rtl/tlc_n_phase.sv
// ----------------------------------------------------------------------------
// light_package / tlc_n_phase
//
// N-phase traffic light controller. One phase is green at a time. Demanding
// phases are served round-robin, starting after the phase served last. Green
// ends on gap-out (own demand gone for GAP_CYCLES) or max-out (MAX_GREEN
// cycles once a conflicting demand has appeared). Every green is followed by
// YELLOW_CYCLES of yellow and at least ALLRED_CYCLES of all-red.
//
// Optional build macro: TLC_PREEMPT_EN
//   Adds preempt / preempt_phase. A preempt request forces the requested
//   phase to be served next. Yellow and all-red times are never shortened.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   sensor         in   [N_PHASES] demand per phase
//   preempt        in   preemption request        (TLC_PREEMPT_EN only)
//   preempt_phase  in   phase to preempt to       (TLC_PREEMPT_EN only)
//   light          out  [N_PHASES] colors, one light per phase
//   cur_phase      out  phase currently or last served
// ----------------------------------------------------------------------------

package light_package;
    typedef enum logic [1:0] {
        red    = 2'd0,
        yellow = 2'd1,
        green  = 2'd2
    } colors;
endpackage

module tlc_n_phase
    import light_package::*;
#(
    parameter int unsigned N_PHASES      = 3,
    parameter int unsigned GAP_CYCLES    = 5,
    parameter int unsigned MAX_GREEN     = 10,
    parameter int unsigned YELLOW_CYCLES = 2,
    parameter int unsigned ALLRED_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_PHASES-1:0]         sensor,
`ifdef TLC_PREEMPT_EN
    input  logic                        preempt,
    input  logic [$clog2(N_PHASES)-1:0] preempt_phase,
`endif
    output colors                       light [N_PHASES],
    output logic [$clog2(N_PHASES)-1:0] cur_phase
);

    localparam int unsigned PW   = $clog2(N_PHASES);
    localparam int unsigned GW   = $clog2(GAP_CYCLES + 1);
    localparam int unsigned MW   = $clog2(MAX_GREEN + 1);
    localparam int unsigned TMAX = (YELLOW_CYCLES > ALLRED_CYCLES) ? YELLOW_CYCLES : ALLRED_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [GW-1:0] GAP_LIM    = GW'(GAP_CYCLES);
    localparam logic [MW-1:0] MAX_LIM    = MW'(MAX_GREEN);
    localparam logic [PW-1:0] LAST_PHASE = PW'(N_PHASES - 1);

    typedef enum logic [1:0] {
        ALLRED = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   phase_n;
    logic [GW-1:0]   gap_ctr, gap_n, next_gap;
    logic [MW-1:0]   max_ctr, max_n, next_max;
    logic [TW-1:0]   tmr, tmr_n;
    // Set by reset so the very first all-red needs no hold, whatever
    // ALLRED_CYCLES is; cleared by the first grant.
    logic            boot_hold, boot_n;

    logic            rr_found;
    logic [PW-1:0]   rr_grant;
    logic [PW-1:0]   rr_idx;
    logic [N_PHASES-1:0] others;
    logic            gap_inc, max_inc, hold_met;
    logic            preempt_other, preempt_own, preempt_grant;

    // Round-robin search: cur_phase+1, cur_phase+2, ... ending on cur_phase.
    always_comb begin
        rr_found = 1'b0;
        rr_grant = cur_phase;
        rr_idx   = cur_phase;
        for (int unsigned i = 1; i <= N_PHASES; i++) begin
            rr_idx = PW'((32'(cur_phase) + i) % N_PHASES);
            if (!rr_found && sensor[rr_idx]) begin
                rr_found = 1'b1;
                rr_grant = rr_idx;
            end
        end
    end

`ifdef TLC_PREEMPT_EN
    always_comb begin
        preempt_grant = preempt && (32'(preempt_phase) < N_PHASES);
        preempt_own   = preempt && (preempt_phase == cur_phase);
        preempt_other = preempt && (preempt_phase != cur_phase);
    end
`else
    always_comb begin
        preempt_grant = 1'b0;
        preempt_own   = 1'b0;
        preempt_other = 1'b0;
    end
`endif

    always_comb begin
        state_n  = state;
        phase_n  = cur_phase;
        gap_n    = gap_ctr;
        max_n    = max_ctr;
        tmr_n    = tmr;
        boot_n   = boot_hold;
        others   = sensor;
        others[cur_phase] = 1'b0;
        gap_inc  = 1'b0;
        max_inc  = 1'b0;
        next_gap = gap_ctr;
        next_max = max_ctr;
        hold_met = 1'b0;

        unique case (state)
            ALLRED: begin
                hold_met = boot_hold || ((32'(tmr) + 32'd1) >= ALLRED_CYCLES);
                if (!hold_met) begin
                    tmr_n = tmr + TW'(1);
                end else if (preempt_grant || rr_found) begin
`ifdef TLC_PREEMPT_EN
                    phase_n = preempt_grant ? preempt_phase : rr_grant;
`else
                    phase_n = rr_grant;
`endif
                    state_n = GREEN;
                    tmr_n   = '0;
                    gap_n   = '0;
                    max_n   = '0;
                    boot_n  = 1'b0;
                end
            end

            GREEN: begin
                // Both counters are sticky: once started they run to expiry.
                gap_inc  = !sensor[cur_phase] || (gap_ctr != '0);
                max_inc  = (|others) || (max_ctr != '0);
                next_gap = gap_ctr + GW'(gap_inc);
                next_max = preempt_own ? '0 : (max_ctr + MW'(max_inc));
                if ((next_gap == GAP_LIM) || (next_max == MAX_LIM) || preempt_other) begin
                    state_n = YELLOW;
                    gap_n   = '0;
                    max_n   = '0;
                    tmr_n   = '0;
                end else begin
                    gap_n   = next_gap;
                    max_n   = next_max;
                end
            end

            YELLOW: begin
                if ((32'(tmr) + 32'd1) == YELLOW_CYCLES) begin
                    state_n = ALLRED;
                    tmr_n   = '0;
                end else begin
                    tmr_n   = tmr + TW'(1);
                end
            end

            default: begin
                state_n = ALLRED;
                tmr_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ALLRED;
            cur_phase <= LAST_PHASE;
            gap_ctr   <= '0;
            max_ctr   <= '0;
            tmr       <= '0;
            boot_hold <= 1'b1;
        end else begin
            state     <= state_n;
            cur_phase <= phase_n;
            gap_ctr   <= gap_n;
            max_ctr   <= max_n;
            tmr       <= tmr_n;
            boot_hold <= boot_n;
        end
    end

    // Moore decode: only the served phase can be non-red.
    always_comb begin
        for (int unsigned p = 0; p < N_PHASES; p++) begin
            light[p] = red;
            if (PW'(p) == cur_phase) begin
                if (state == GREEN) begin
                    light[p] = green;
                end else if (state == YELLOW) begin
                    light[p] = yellow;
                end
            end
        end
    end

endmodule

// File: tb/tb_tlc_n_phase.sv
// ----------------------------------------------------------------------------
// tb_tlc_n_phase
//
// Bench for tlc_n_phase with N_PHASES=3 and default timing. Each step drives
// the sensors, pushes the light pattern and cur_phase expected after the next
// rising edge to a scoreboard, then pops and compares after that edge.
// The preemption scenario is included when TLC_PREEMPT_EN is defined.
// ----------------------------------------------------------------------------

module tb_tlc_n_phase;
    import light_package::*;

    localparam int R = 0;
    localparam int G = 1;
    localparam int Y = 2;

    typedef struct packed {
        logic [5:0] lights;
        logic [1:0] phase;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  sensor;
    colors       light [3];
    logic [1:0]  cur_phase;
`ifdef TLC_PREEMPT_EN
    logic        preempt;
    logic [1:0]  preempt_phase;
`endif

    logic [5:0]  lv;
    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    assign lv = {light[2], light[1], light[0]};

    always #5 clk = ~clk;

    tlc_n_phase #(
        .N_PHASES      (3),
        .GAP_CYCLES    (5),
        .MAX_GREEN     (10),
        .YELLOW_CYCLES (2),
        .ALLRED_CYCLES (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sensor        (sensor),
`ifdef TLC_PREEMPT_EN
        .preempt       (preempt),
        .preempt_phase (preempt_phase),
`endif
        .light         (light),
        .cur_phase     (cur_phase)
    );

    function automatic logic [5:0] exp_lv(input int kind, input int ph);
        logic [5:0] v;
        for (int p = 0; p < 3; p++) begin
            v[2*p +: 2] = red;
            if (p == ph && kind == G) v[2*p +: 2] = green;
            if (p == ph && kind == Y) v[2*p +: 2] = yellow;
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] s, input int kind, input int ph);
        exp_t e;
        sensor   = s;
        e.lights = exp_lv(kind, ph);
        e.phase  = 2'(ph);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check({tag, "/light"}, 32'(lv), 32'(e.lights));
        check({tag, "/phase"}, 32'(cur_phase), 32'(e.phase));
    endtask

    task automatic run(input string tag, input logic [2:0] s, input int kind, input int ph, input int n);
        for (int i = 0; i < n; i++) step(tag, s, kind, ph);
    endtask

    task automatic do_reset();
        sensor = 3'b000;
        reset  = 1'b1;
        #1;
        check("rst/light", 32'(lv), 32'(exp_lv(R, 0)));
        check("rst/phase", 32'(cur_phase), 32'd2);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        sensor = 3'b000;
`ifdef TLC_PREEMPT_EN
        preempt       = 1'b0;
        preempt_phase = 2'd0;
`endif
        @(posedge clk);
        #1;
        do_reset();

        // Single pulse of demand on phase 0: gap-out, then all red forever.
        step("gap", 3'b001, G, 0);
        run ("gap", 3'b000, G, 0, 4);
        run ("gap", 3'b000, Y, 0, 2);
        run ("gap", 3'b000, R, 0, 5);
        // Only the last-served phase asks again: it is re-granted.
        step("regrant", 3'b001, G, 0);

        // Two phases held: max-out on 0, then 1, then back to 0.
        do_reset();
        step("max0", 3'b011, G, 0);
        run ("max0", 3'b011, G, 0, 9);
        run ("max0", 3'b011, Y, 0, 2);
        step("max0", 3'b011, R, 0);
        step("max1", 3'b011, G, 1);
        run ("max1", 3'b011, G, 1, 9);
        run ("max1", 3'b011, Y, 1, 2);
        step("max1", 3'b011, R, 1);
        step("max1", 3'b011, G, 0);

        // Sticky gap: demand returns but the gap counter keeps running.
        do_reset();
        step("sticky", 3'b001, G, 0);
        run ("sticky", 3'b000, G, 0, 2);
        run ("sticky", 3'b001, G, 0, 2);
        step("sticky", 3'b001, Y, 0);

        // Round-robin wrap: after phase 1, phase 2 goes before phase 0.
        do_reset();
        step("rr", 3'b010, G, 1);
        run ("rr", 3'b000, G, 1, 4);
        step("rr", 3'b000, Y, 1);
        step("rr", 3'b101, Y, 1);
        step("rr", 3'b101, R, 1);
        step("rr", 3'b101, G, 2);

        // Reset between edges while green.
        do_reset();
        run ("arst", 3'b001, G, 0, 2);
        #3;
        reset = 1'b1;
        #1;
        check("arst/light", 32'(lv), 32'(exp_lv(R, 0)));
        check("arst/phase", 32'(cur_phase), 32'd2);
        @(posedge clk);
        #1;
        check("arst_hold/light", 32'(lv), 32'(exp_lv(R, 0)));
        #2;
        reset  = 1'b0;
        sensor = 3'b100;
        step("arst", 3'b100, G, 2);

`ifdef TLC_PREEMPT_EN
        // Preempt to phase 2 at green cycle 3 of phase 0.
        do_reset();
        run ("pre", 3'b011, G, 0, 3);
        preempt       = 1'b1;
        preempt_phase = 2'd2;
        step("pre", 3'b011, Y, 0);
        step("pre", 3'b000, Y, 0);
        step("pre", 3'b000, R, 0);
        step("pre", 3'b000, G, 2);
        // Max counter frozen while preempt stays on the served phase.
        run ("pre_frz", 3'b111, G, 2, 12);
        preempt = 1'b0;
        run ("pre_rel", 3'b111, G, 2, 9);
        step("pre_rel", 3'b111, Y, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
